pp_pipeline_accel_postprocess_denorm: RTL and testbench
=======================================================

PP_PIPELINE_ACCEL_POSTPROCESS_DENORM -- requirements
Module: pp_pipeline_accel_postprocess_denorm

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 4, fractional bits of gain; legal range 1..7.
REQ-002 SHALL have parameter PIX_W, default 8, bits per channel; 3 channels packed per pixel.
REQ-003 SHALL have port ap_clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port ap_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports ap_start in 1, ap_done out 1, ap_idle out 1, ap_ready out 1; block-level start/done handshake.
REQ-006 SHALL have ports in_mat_dout in 24 (normalized pixel; ch0 [7:0], ch1 [15:8], ch2 [23:16], each signed), in_mat_empty_n in 1, in_mat_read out 1.
REQ-007 SHALL have ports out_mat_din out 24 (unsigned pixel, same packing), out_mat_full_n in 1, out_mat_write out 1.
REQ-008 SHALL have ports loop_count in 32 (signed pixel count), mean_0/1/2 in 8 (unsigned), gain_0/1/2 in 8 (signed, Q(8-FRAC_BITS).FRAC_BITS).

Function
REQ-009 SHALL compute per channel: out = sat_u8(mean + ((y*gain + 2^(FRAC_BITS-1)) >>> FRAC_BITS)); y, gain signed 8-bit; product 16-bit signed; arithmetic shift; sum 10-bit signed; saturate to 0..255.
REQ-010 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-011 IDLE: ap_idle=1; on ap_start=1 latch loop_count, mean_*, gain_*, clear read counter, go RUN; ap_start in any other state SHALL be ignored.
REQ-012 RUN: issue one read per unstalled cycle while read counter < loop_count (signed compare); on last read accepted pulse ap_ready for one cycle and go DRAIN.
REQ-013 loop_count <= 0: no reads/writes; RUN SHALL pass to DONE next cycle with ap_ready pulsed.
REQ-014 Pipeline SHALL be 3 stages: S1 capture FIFO data, S2 multiply, S3 round/add/saturate and write; latency from in_mat_read to out_mat_write = 2 cycles when unstalled; throughput 1 pixel/cycle.
REQ-015 Global stall = (S1 wants read & in_mat_empty_n=0) | (S3 valid & out_mat_full_n=0); during stall no stage advances and no counter changes.
REQ-016 in_mat_read SHALL assert only when S1 active and not stalled; out_mat_write only when S3 valid and not stalled.
REQ-017 DRAIN: go DONE when all stage valids are 0.
REQ-018 DONE: ap_done=1 for exactly one cycle, then IDLE.
REQ-019 Write count SHALL equal read count; no pixel dropped or duplicated under any empty/full pattern, including empty and full both low in same cycle.
REQ-020 Latched parameters SHALL stay constant for the whole run even if inputs change.

Reset
REQ-021 On ap_rst_n=0 (asynchronous) SHALL enter IDLE, clear all stage valids and counters; outputs ap_done=0, ap_ready=0, in_mat_read=0, out_mat_write=0, out_mat_din=0, ap_idle=1.
REQ-022 Reset mid-run SHALL abort immediately; no write after reset deassertion until a new ap_start.

Structure
REQ-023 Shared package pp_pipeline_accel_pkg SHALL hold FRAC_BITS default, PIX_W, packed pixel type, FSM state enum.
REQ-024 SHALL instantiate sub-module pp_pipeline_accel_denorm_lane three times (one per channel; multiply, round, add, saturate; stall-enabled registers).

Verification
REQ-025 mean=128, gain=16, y=10 all channels, loop_count=1 -> out_mat_din=0x8A8A8A, ap_done one cycle after final write.
REQ-026 mean=255, gain=127, y=127 -> 0xFF per channel; mean=0, gain=16, y=0x80 -> 0x00 (saturation both ends).
REQ-027 mean=0, gain=8: y=1 -> 1; y=0xFF (-1) -> 0 (rounding).
REQ-028 loop_count=720, random empty_n/full_n toggling 30% -> exactly 720 writes, order preserved, matches reference model.
REQ-029 loop_count=0 -> zero reads/writes, ap_ready then ap_done pulse; reset asserted mid-run of 100 -> outputs reset values, no further writes.

Source files
------------

// File: rtl/pp_pipeline_accel_pkg.sv
// Shared constants and types for the accelerator post-processing stage:
// default fixed-point format, packed pixel layout and block FSM states.
package pp_pipeline_accel_pkg;

  localparam int PP_FRAC_BITS = 4;
  localparam int PP_PIX_W     = 8;

  typedef struct packed {
    logic [PP_PIX_W-1:0] ch2;
    logic [PP_PIX_W-1:0] ch1;
    logic [PP_PIX_W-1:0] ch0;
  } pix_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pp_pipeline_accel_postprocess_denorm_if.sv
// Pixel stream bundle: FIFO-style input (dout/empty_n/read) and output
// (din/full_n/write). The slave modport is the denorm block's view.
interface pp_pipeline_accel_postprocess_denorm_if #(
  parameter int PIX_W = pp_pipeline_accel_pkg::PP_PIX_W
);
  logic [3*PIX_W-1:0] in_mat_dout;
  logic               in_mat_empty_n;
  logic               in_mat_read;
  logic [3*PIX_W-1:0] out_mat_din;
  logic               out_mat_full_n;
  logic               out_mat_write;

  modport master (
    output in_mat_dout, in_mat_empty_n, out_mat_full_n,
    input  in_mat_read, out_mat_din, out_mat_write
  );

  modport slave (
    input  in_mat_dout, in_mat_empty_n, out_mat_full_n,
    output in_mat_read, out_mat_din, out_mat_write
  );
endinterface

// File: rtl/pp_pipeline_accel_denorm_lane.sv
// One colour channel of the denormaliser: out = sat_u8(mean + round(y*gain)).
// Data registers advance only when en is high (global stall freezes them).
module pp_pipeline_accel_denorm_lane #(
  parameter int FRAC_BITS = 4,
  parameter int PIX_W     = 8
) (
  input  logic                    ap_clk,
  input  logic                    en,
  input  logic        [PIX_W-1:0] y_in,
  input  logic signed [PIX_W-1:0] gain,
  input  logic        [PIX_W-1:0] mean,
  output logic        [PIX_W-1:0] pix_out
);

  localparam int PW = 2 * PIX_W;
  localparam int SW = 2 * PIX_W + 2;
  localparam logic signed [PW-1:0] RND     = PW'(1) << (FRAC_BITS - 1);
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
    return (p + RND) >>> FRAC_BITS;
  endfunction

  function automatic logic [PIX_W-1:0] sat_pix(input logic signed [SW-1:0] s);
    if (s < 0)            return '0;
    else if (s > PIX_MAX) return '1;
    else                  return s[PIX_W-1:0];
  endfunction

  logic signed [PIX_W-1:0] y_p0;
  logic signed [PW-1:0]    prod_p1;
  logic signed [PW-1:0]    shr_p1;
  logic signed [SW-1:0]    sum_p1;

  // S1 capture -> S2 multiply
  always_ff @(posedge ap_clk) begin
    if (en) begin
      y_p0    <= $signed(y_in);
      prod_p1 <= y_p0 * gain;
    end
  end

  // S3: round, add mean, saturate; sum kept wide so large gain*y cannot wrap
  always_comb begin
    shr_p1  = round_shift(prod_p1);
    sum_p1  = $signed({{(PIX_W+2){1'b0}}, mean}) + $signed({{2{shr_p1[PW-1]}}, shr_p1});
    pix_out = sat_pix(sum_p1);
  end

endmodule

// File: rtl/pp_pipeline_accel_postprocess_denorm.sv
// Block-level denormaliser: reads loop_count signed pixels from a FIFO, applies
// per-channel gain/mean with saturation, writes unsigned pixels to a FIFO.
module pp_pipeline_accel_postprocess_denorm
  import pp_pipeline_accel_pkg::*;
#(
  parameter int FRAC_BITS = PP_FRAC_BITS,
  parameter int PIX_W     = PP_PIX_W
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  pp_pipeline_accel_postprocess_denorm_if.slave mat,
  input  logic signed [31:0]      loop_count,
  input  logic        [PIX_W-1:0] mean_0,
  input  logic        [PIX_W-1:0] mean_1,
  input  logic        [PIX_W-1:0] mean_2,
  input  logic signed [PIX_W-1:0] gain_0,
  input  logic signed [PIX_W-1:0] gain_1,
  input  logic signed [PIX_W-1:0] gain_2
);

  state_t                  state_q, state_d;
  logic signed [31:0]      cnt_q;
  logic signed [31:0]      lc_q;
  logic [2:0][PIX_W-1:0]   mean_q;
  logic [2:0][PIX_W-1:0]   gain_q;
  logic                    vld_p0, vld_p1;
  logic [3*PIX_W-1:0]      lane_pix;
  logic                    start_acc, want_rd, stall, adv, rd_fire, wr_fire, last_rd;

  assign start_acc = (state_q == ST_IDLE) && ap_start;
  assign want_rd   = (state_q == ST_RUN) && (cnt_q < lc_q);
  assign stall     = (want_rd && !mat.in_mat_empty_n) || (vld_p1 && !mat.out_mat_full_n);
  assign adv       = !stall;
  assign rd_fire   = want_rd && adv;
  assign wr_fire   = vld_p1 && adv;
  assign last_rd   = rd_fire && (cnt_q == lc_q - 32'sd1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // DRAIN exits on the edge that empties the pipe, so ap_done trails the last write by one cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ap_start) state_d = ST_RUN;
      ST_RUN:   if (lc_q <= 0) state_d = ST_DONE;
                else if (last_rd) state_d = ST_DRAIN;
      ST_DRAIN: if (!vld_p0 && (!vld_p1 || wr_fire)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ap_idle           = (state_q == ST_IDLE);
    ap_done           = (state_q == ST_DONE);
    ap_ready          = (state_q == ST_RUN) && ((lc_q <= 0) || last_rd);
    mat.in_mat_read   = rd_fire;
    mat.out_mat_write = wr_fire;
    mat.out_mat_din   = vld_p1 ? lane_pix : '0;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q  <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      if (start_acc)    cnt_q <= '0;
      else if (rd_fire) cnt_q <= cnt_q + 32'sd1;
      if (adv) begin
        vld_p0 <= rd_fire;
        vld_p1 <= vld_p0;
      end
    end
  end

  // Run parameters are frozen at start so mid-run input changes are harmless
  always_ff @(posedge ap_clk) begin
    if (start_acc) begin
      lc_q   <= loop_count;
      mean_q <= {mean_2, mean_1, mean_0};
      gain_q <= {gain_2, gain_1, gain_0};
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_lane
    pp_pipeline_accel_denorm_lane #(
      .FRAC_BITS(FRAC_BITS),
      .PIX_W    (PIX_W)
    ) u_lane (
      .ap_clk (ap_clk),
      .en     (adv),
      .y_in   (mat.in_mat_dout[c*PIX_W +: PIX_W]),
      .gain   (gain_q[c]),
      .mean   (mean_q[c]),
      .pix_out(lane_pix[c*PIX_W +: PIX_W])
    );
  end

endmodule

// File: tb/tb_pp_pipeline_accel_postprocess_denorm.sv
// Directed bench for the denormaliser: FIFO source/sink models around the DUT,
// expected pixels queued at stimulus time and compared as writes appear.
module tb_pp_pipeline_accel_postprocess_denorm;
  import pp_pipeline_accel_pkg::*;

  localparam int FRAC = 4;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              ap_start;
  logic              ap_done, ap_idle, ap_ready;
  logic signed [31:0] loop_count;
  logic [7:0]        mean_0, mean_1, mean_2;
  logic signed [7:0] gain_0, gain_1, gain_2;

  pp_pipeline_accel_postprocess_denorm_if mat_if ();

  pp_pipeline_accel_postprocess_denorm dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ap_start  (ap_start),
    .ap_done   (ap_done),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .mat       (mat_if),
    .loop_count(loop_count),
    .mean_0    (mean_0),
    .mean_1    (mean_1),
    .mean_2    (mean_2),
    .gain_0    (gain_0),
    .gain_1    (gain_1),
    .gain_2    (gain_2)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [23:0] src_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] e_pix, dummy;
  bit          rd_pend  = 0;
  bit          rnd_en   = 0;
  int          reads, writes, rdy_cnt, done_cnt;
  int          first_rd, last_rd, first_wr, last_wr, rdy_cyc, done_cyc;
  int          jlc;
  logic [7:0]  jm[3];
  logic [7:0]  jg[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_ch(input logic [7:0] y, input logic [7:0] g, input logic [7:0] m);
    int p, r, s;
    p = int'($signed(y)) * int'($signed(g));
    r = (p + (1 << (FRAC - 1))) >>> FRAC;
    s = int'(m) + r;
    if (s < 0)   return 8'h00;
    if (s > 255) return 8'hFF;
    return s[7:0];
  endfunction

  // Source FIFO and sink backpressure, updated just after each rising edge
  always @(posedge ap_clk) begin
    cyc++;
    #1;
    if (rd_pend) begin
      if (src_q.size() > 0) dummy = src_q.pop_front();
      rd_pend = 0;
    end
    if (src_q.size() > 0) begin
      mat_if.in_mat_dout    = src_q[0];
      mat_if.in_mat_empty_n = rnd_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end else begin
      mat_if.in_mat_dout    = '0;
      mat_if.in_mat_empty_n = 1'b0;
    end
    mat_if.out_mat_full_n = rnd_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Monitor and scoreboard, sampled on the falling edge
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (mat_if.in_mat_read) begin
        rd_pend = 1;
        if (reads == 0) first_rd = cyc;
        last_rd = cyc;
        reads++;
      end
      if (mat_if.out_mat_write) begin
        if (writes == 0) first_wr = cyc;
        last_wr = cyc;
        writes++;
        if (exp_q.size() == 0) check("wr_unexpected", exp_q.size(), 1);
        else begin
          e_pix = exp_q.pop_front();
          check("wr_data", 32'(mat_if.out_mat_din), 32'(e_pix));
        end
      end
      if (ap_ready) begin rdy_cnt++;  rdy_cyc  = cyc; end
      if (ap_done)  begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic set_params(input int lc, input logic [7:0] m0, m1, m2, g0, g1, g2);
    jlc = lc;
    jm[0] = m0; jm[1] = m1; jm[2] = m2;
    jg[0] = g0; jg[1] = g1; jg[2] = g2;
    loop_count = lc;
    mean_0 = m0; mean_1 = m1; mean_2 = m2;
    gain_0 = g0; gain_1 = g1; gain_2 = g2;
  endtask

  task automatic push_pix(input pix_t y);
    pix_t e;
    e.ch0 = ref_ch(y.ch0, jg[0], jm[0]);
    e.ch1 = ref_ch(y.ch1, jg[1], jm[1]);
    e.ch2 = ref_ch(y.ch2, jg[2], jm[2]);
    src_q.push_back(y);
    exp_q.push_back(e);
  endtask

  task automatic kick(input bit rnd);
    rnd_en = rnd;
    @(posedge ap_clk); #1;
    reads = 0; writes = 0; rdy_cnt = 0; done_cnt = 0;
    first_rd = 0; last_rd = 0; first_wr = 0; last_wr = 0; rdy_cyc = 0; done_cyc = 0;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start   = 1'b0;
    loop_count = 3;
    mean_0 = 8'($urandom); mean_1 = 8'($urandom); mean_2 = 8'($urandom);
    gain_0 = 8'($urandom); gain_1 = 8'($urandom); gain_2 = 8'($urandom);
  endtask

  task automatic go(input bit rnd, input int maxc);
    int nexp, n;
    nexp = (jlc > 0) ? jlc : 0;
    kick(rnd);
    if (jlc >= 500) begin
      repeat (10) @(posedge ap_clk);
      #1 ap_start = 1'b1;
      @(posedge ap_clk); #1 ap_start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < maxc) begin
      @(posedge ap_clk);
      n++;
    end
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("done_pulses", done_cnt, 1);
    check("ready_pulses", rdy_cnt, 1);
    check("read_count", reads, nexp);
    check("write_count", writes, nexp);
    check("exp_left", exp_q.size(), 0);
    check("idle_after", 32'(ap_idle), 1);
    if (nexp > 0) begin
      check("done_after_last_wr", done_cyc - last_wr, 1);
      check("ready_at_last_rd", rdy_cyc, last_rd);
      if (!rnd) begin
        check("latency_rd_wr", first_wr - first_rd, 2);
        check("throughput", last_rd - first_rd, nexp - 1);
      end
    end else begin
      check("done_after_ready", done_cyc - rdy_cyc, 1);
    end
    rnd_en = 0;
    src_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int wr0, rd0;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    set_params(0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    mat_if.in_mat_dout    = '0;
    mat_if.in_mat_empty_n = 1'b0;
    mat_if.out_mat_full_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_idle", 32'(ap_idle), 1);
    check("rst_done", 32'(ap_done), 0);
    check("rst_ready", 32'(ap_ready), 0);
    check("rst_read", 32'(mat_if.in_mat_read), 0);
    check("rst_write", 32'(mat_if.out_mat_write), 0);
    check("rst_din", 32'(mat_if.out_mat_din), 0);
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;

    // Unity gain, single pixel: 128 + 10 = 0x8A
    set_params(1, 8'd128, 8'd128, 8'd128, 8'd16, 8'd16, 8'd16);
    push_pix(24'h0A0A0A);
    go(0, 50);

    // Saturation high then low
    set_params(1, 8'd255, 8'd255, 8'd255, 8'd127, 8'd127, 8'd127);
    push_pix(24'h7F7F7F);
    go(0, 50);
    set_params(1, 8'd0, 8'd0, 8'd0, 8'd16, 8'd16, 8'd16);
    push_pix(24'h808080);
    go(0, 50);

    // Rounding at half gain: +1 -> 1, -1 -> 0
    set_params(2, 8'd0, 8'd0, 8'd0, 8'd8, 8'd8, 8'd8);
    push_pix(24'h010101);
    push_pix(24'hFFFFFF);
    go(0, 50);

    // Distinct per-channel parameters, unstalled streaming
    set_params(20, 8'd10, 8'd100, 8'd200, 8'd16, 8'hF0, 8'd24);
    for (int i = 0; i < 20; i++) push_pix(24'($urandom));
    go(0, 100);

    // Long run with random empty/full and a stray ap_start mid-run
    set_params(720, 8'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 720; i++) push_pix(24'($urandom));
    go(1, 6000);

    // Empty job sizes: stray pixels in the source must not be read
    set_params(0, 8'd1, 8'd2, 8'd3, 8'd16, 8'd16, 8'd16);
    src_q.push_back(24'h123456);
    src_q.push_back(24'h654321);
    go(0, 20);
    set_params(-5, 8'd1, 8'd2, 8'd3, 8'd16, 8'd16, 8'd16);
    src_q.push_back(24'h123456);
    go(0, 20);

    // Reset in the middle of a 100-pixel job
    set_params(100, 8'd50, 8'd60, 8'd70, 8'd20, 8'd30, 8'd40);
    for (int i = 0; i < 100; i++) push_pix(24'($urandom));
    kick(1);
    repeat (40) @(posedge ap_clk);
    #3 ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("mid_rst_idle", 32'(ap_idle), 1);
    check("mid_rst_done", 32'(ap_done), 0);
    check("mid_rst_ready", 32'(ap_ready), 0);
    check("mid_rst_read", 32'(mat_if.in_mat_read), 0);
    check("mid_rst_write", 32'(mat_if.out_mat_write), 0);
    check("mid_rst_din", 32'(mat_if.out_mat_din), 0);
    check("mid_rst_partial", 32'(writes < 100), 1);
    repeat (2) @(posedge ap_clk);
    #1;
    rnd_en = 0;
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(24'($urandom));
    wr0 = writes;
    rd0 = reads;
    ap_rst_n = 1'b1;
    repeat (20) @(posedge ap_clk);
    @(negedge ap_clk);
    check("post_rst_writes", writes, wr0);
    check("post_rst_reads", reads, rd0);
    check("post_rst_idle", 32'(ap_idle), 1);
    src_q.delete();

    // Recovery after abort
    set_params(3, 8'd128, 8'd128, 8'd128, 8'd16, 8'd16, 8'd16);
    push_pix(24'h0A0B0C);
    push_pix(24'hF6F5F4);
    push_pix(24'h000102);
    go(0, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
